// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation codes,
// the one-bit full-adder cell and the parameter legality check.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One-bit full adder: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  // The carry chain is cut into equal segments, so WIDTH must divide evenly.
  function automatic bit params_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_segment.sv
// Combinational SEG-bit ripple-carry segment built from the full-adder cell.
// Also exposes the carry into its MSB so the top segment can form overflow.
module pipe_adder_segment
  import addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] c;

  // Ripple the carry through the segment one bit at a time.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor. The carry chain is split into STAGES
// segments with a register between them; unconsumed operand bits travel
// forward with the carry and finished sum bits accumulate, so the output
// presents one complete operation per beat. A single global advance
// signal gives full backpressure: the whole pipe moves or holds together.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG   = WIDTH / STAGES;
  localparam bit LEGAL = params_legal(WIDTH, STAGES);

  if (!LEGAL) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              adv;
  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  sum_p;
  logic              cout_p;
  logic              ovf_p;

  // The pipe may move whenever the output slot is empty or being drained.
  assign adv       = !vld_p[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = sum_p;
  assign out_cout  = cout_p;
  assign out_ovf   = ovf_p;

  // Valid bits shift with the data; bubbles move only on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still to be consumed at this stage, current segment at the bottom.
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0]          a_in;
    logic [RW-1:0]          b_in;
    logic                   c_in;
    logic [SEG-1:0]         seg_s;
    logic                   seg_co;
    logic [(k+1)*SEG-1:0]   s_acc;

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1: invert B and inject the carry at bit 0.
      assign a_in  = in_a;
      assign b_in  = (in_op == OP_SUB) ? ~in_b : in_b;
      assign c_in  = (in_op == OP_SUB);
      assign s_acc = seg_s;
    end else begin : g_src
      assign a_in  = g_st[k-1].g_mid.a_p;
      assign b_in  = g_st[k-1].g_mid.b_p;
      assign c_in  = g_st[k-1].g_mid.cy_p;
      assign s_acc = {seg_s, g_st[k-1].g_mid.s_p};
    end

    if (k == STAGES - 1) begin : g_last
      logic seg_cm;

      pipe_adder_segment #(.SEG(SEG)) u_seg (
        .a    (a_in[SEG-1:0]),
        .b    (b_in[SEG-1:0]),
        .cin  (c_in),
        .sum  (seg_s),
        .cout (seg_co),
        .cmsb (seg_cm)
      );

      // Final stage: complete result, carry out and signed overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_p  <= '0;
          cout_p <= 1'b0;
          ovf_p  <= 1'b0;
        end else if (adv) begin
          sum_p  <= s_acc;
          cout_p <= seg_co;
          ovf_p  <= seg_co ^ seg_cm;
        end
      end
    end else begin : g_mid
      logic                 cmsb_unused;
      logic [RW-SEG-1:0]    a_p;
      logic [RW-SEG-1:0]    b_p;
      logic                 cy_p;
      logic [(k+1)*SEG-1:0] s_p;

      pipe_adder_segment #(.SEG(SEG)) u_seg (
        .a    (a_in[SEG-1:0]),
        .b    (b_in[SEG-1:0]),
        .cin  (c_in),
        .sum  (seg_s),
        .cout (seg_co),
        .cmsb (cmsb_unused)
      );

      // Stage boundary: forward remaining operands, segment carry and partial sum.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_p  <= a_in[RW-1:SEG];
          b_p  <= b_in[RW-1:SEG];
          cy_p <= seg_co;
          s_p  <= s_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors on a 16-bit/4-stage instance
// plus randomised streams on 8-bit/1-stage and 32-bit/8-stage instances.
// Expected results go into queues at acceptance; monitors pop on each
// output handshake and also check latency net of stall cycles.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         rst_sw_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int n_vec  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int stalls = 0;
  bit strict = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
    int           st;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, queue the expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic [W-1:0] es, input logic ec, input logic eo);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (strict) chk("in_ready_full_rate", w, 0);
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.s = es; e.c = ec; e.o = eo; e.acc = cyc; e.st = stalls;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk); w++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Main monitor: count stall cycles, pop and compare on each output handshake.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        if (out_valid && !out_ready) stalls++;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            mon_e = q.pop_front();
            chk("sum", out_sum, mon_e.s);
            chk("cout", out_cout, mon_e.c);
            chk("ovf", out_ovf, mon_e.o);
            chk("latency", cyc - mon_e.acc, S + stalls - mon_e.st);
          end
        end
      end
    end
  end

  initial begin
    rst_sw_n = 1'b0;
    #12 rst_sw_n = 1'b1;
  end

  // Main directed sequence.
  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_out_cout", out_cout, 0);
    chk("reset_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Stream then reset while results are in flight and one is on the output.
    for (int i = 0; i < 5; i++) begin
      send(W'(i + 1), 16'h0100, 1'b0, W'(16'h0101 + i), 1'b0, 1'b0);
    end
    idle();
    #3;
    chk("valid_before_reset", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", out_valid, 0);
    chk("reset_clears_sum", out_sum, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_midreset", in_ready, 1);
    chk("no_valid_after_midreset", out_valid, 0);

    // Directed corner vectors.
    send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Full-rate stream: A = i, B = 3i, sum = 4i.
    strict = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(W'(i), W'(3 * i), 1'b0, W'(4 * i), 1'b0, 1'b0);
    end
    strict = 1'b0;
    idle();
    drain();

    // Backpressure: hold out_ready low for 5 cycles with a result presented.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    send(16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle();
    #1;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk("bp_result_presented", out_valid, 1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        @(negedge clk); #1;
      end
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_sum_held", out_sum, 16'h2345);
      chk("bp_cout_held", out_cout, 0);
      chk("bp_ovf_held", out_ovf, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle();
    drain();

    // Wait for the parameter-sweep instances.
    w = 0;
    while (!(g_sw[0].done && g_sw[1].done) && w < 30000) begin
      @(negedge clk); w++;
    end
    chk("sweep_complete", {g_sw[1].done, g_sw[0].done}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=32/STAGES=8, random traffic.
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int SW = (g == 0) ? 8 : 32;
    localparam int SS = (g == 0) ? 1 : 8;

    logic          iv, ir, op, ov, ordy, oc, oo;
    logic [SW-1:0] a, b, os;
    logic [SW+1:0] eq[$];
    int            aq[$];
    int            sq[$];
    int            st = 0;
    bit            done = 1'b0;

    pipelined_addsub #(.WIDTH(SW), .STAGES(SS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_sw_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (a),
      .in_b      (b),
      .in_op     (op),
      .out_valid (ov),
      .out_ready (ordy),
      .out_sum   (os),
      .out_cout  (oc),
      .out_ovf   (oo)
    );

    // Reference: wide unsigned sum for carry, wide signed range test for overflow.
    function automatic logic [SW+1:0] model(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic o);
      logic [SW:0]          r;
      logic signed [SW-1:0] sx, sy;
      longint               t, hi, lo;
      logic                 v;
      sx = x; sy = y;
      if (o) r = {1'b0, x} + {1'b0, ~y} + (SW+1)'(1);
      else   r = {1'b0, x} + {1'b0, y};
      t  = o ? (longint'(sx) - longint'(sy)) : (longint'(sx) + longint'(sy));
      hi = (longint'(1) <<< (SW - 1)) - 1;
      lo = -(longint'(1) <<< (SW - 1));
      v  = (t > hi) || (t < lo);
      return {v, r[SW], r[SW-1:0]};
    endfunction

    initial begin
      ordy = 1'b0;
      forever begin
        @(negedge clk);
        ordy = ($urandom_range(3) != 0);
      end
    end

    initial begin
      int w;
      iv = 1'b0; a = '0; b = '0; op = 1'b0;
      repeat (3) @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        if ($urandom_range(3) == 0) begin
          iv = 1'b0;
          @(negedge clk);
        end
        a = SW'($urandom); b = SW'($urandom); op = 1'($urandom_range(1)); iv = 1'b1;
        #1;
        w = 0;
        while (!ir && w < 100) begin
          @(negedge clk); #1; w++;
        end
        if (!ir) begin
          chk($sformatf("w%0d_accept_timeout", SW), 0, 1);
        end else begin
          eq.push_back(model(a, b, op));
          aq.push_back(cyc);
          sq.push_back(st);
        end
      end
      @(negedge clk);
      iv = 1'b0;
      w = 0;
      while (eq.size() != 0 && w < 400) begin
        @(negedge clk); w++;
      end
      chk($sformatf("w%0d_drain", SW), eq.size(), 0);
      done = 1'b1;
    end

    initial begin
      forever begin
        @(negedge clk); #2;
        if (rst_sw_n) begin
          if (ov && !ordy) st++;
          if (ov && ordy) begin
            if (eq.size() == 0) begin
              chk($sformatf("w%0d_unexpected_output", SW), 1, 0);
            end else begin
              chk($sformatf("w%0d_result", SW), {oo, oc, os}, eq.pop_front());
              chk($sformatf("w%0d_latency", SW), cyc - aq.pop_front(), SS + st - sq.pop_front());
            end
          end
        end
      end
    end
  end

endmodule
